// File: rtl/event_seq_waiter.sv
// rtl/event_seq_waiter.sv - in-order event strobe consumer with done/err reporting
//
// Arms on start, then consumes trig[0..N-1] strictly in index order, pulsing
// hit per consumed event. Ends in DONE after the last event or in ERROR on an
// early trigger (or on an idle timeout when EVENT_SEQ_WAITER_TIMEOUT_EN is
// defined). All outputs are registered.
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - synchronous active-low reset
//   start     - arm request, honoured in IDLE/DONE/ERROR only
//   trig      - N event strobes, bit i = event i fired this cycle
//   busy      - high while waiting for events
//   wait_idx  - index currently awaited
//   hit       - one-cycle pulse, awaited event consumed
//   hit_idx   - index consumed, valid with hit
//   done      - sticky, all N events consumed
//   err       - sticky, sequence aborted
//   err_code  - 01 early trigger, 10 timeout, 00 none
//   err_idx   - offending index
//
// Optional feature macro: EVENT_SEQ_WAITER_TIMEOUT_EN

module event_seq_waiter #(
  parameter int N       = 100,
  parameter int IDXW    = $clog2(N),
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N-1:0]    trig,
  output logic            busy,
  output logic [IDXW-1:0] wait_idx,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx,
  output logic            done,
  output logic            err,
  output logic [1:0]      err_code,
  output logic [IDXW-1:0] err_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_busy, w_busy_nxt;
  logic [IDXW-1:0] r_wait_idx, w_wait_idx_nxt;
  logic            r_hit, w_hit_nxt;
  logic [IDXW-1:0] r_hit_idx, w_hit_idx_nxt;
  logic            r_done, w_done_nxt;
  logic            r_err, w_err_nxt;
  logic [1:0]      r_err_code, w_err_code_nxt;
  logic [IDXW-1:0] r_err_idx, w_err_idx_nxt;

  logic            w_early;
  logic [IDXW-1:0] w_early_idx;
  logic            w_trig_k;

`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  logic [CNTW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic [CNTW-1:0] w_tmo_inc;
  assign w_tmo_inc = r_tmo_cnt + CNTW'(1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  // Lowest set trigger strictly above the awaited index. Scanning downward
  // lets the last assignment win, leaving the lowest qualifying j.
  always_comb begin
    w_early     = 1'b0;
    w_early_idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (trig[j] && (j > int'(r_wait_idx))) begin
        w_early     = 1'b1;
        w_early_idx = IDXW'(j);
      end
    end
  end

  assign w_trig_k = trig[r_wait_idx];

  always_comb begin
    w_state_nxt    = r_state;
    w_busy_nxt     = r_busy;
    w_wait_idx_nxt = r_wait_idx;
    w_hit_nxt      = 1'b0;
    w_hit_idx_nxt  = r_hit_idx;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_err_code_nxt = r_err_code;
    w_err_idx_nxt  = r_err_idx;
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
    w_tmo_cnt_nxt  = r_tmo_cnt;
`endif
    case (r_state)
      S_WAIT: begin
        if (w_early) begin
          // An early strobe aborts even when the awaited bit is also set.
          w_state_nxt    = S_ERROR;
          w_busy_nxt     = 1'b0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = 2'b01;
          w_err_idx_nxt  = w_early_idx;
        end else if (w_trig_k) begin
          w_hit_nxt     = 1'b1;
          w_hit_idx_nxt = r_wait_idx;
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
          w_tmo_cnt_nxt = '0;
`endif
          if (r_wait_idx == IDXW'(N - 1)) begin
            w_state_nxt = S_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_wait_idx_nxt = r_wait_idx + IDXW'(1);
          end
        end else begin
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
          w_tmo_cnt_nxt = w_tmo_inc;
          if (w_tmo_inc == CNTW'(TIMEOUT)) begin
            w_state_nxt    = S_ERROR;
            w_busy_nxt     = 1'b0;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = 2'b10;
            w_err_idx_nxt  = r_wait_idx;
          end
`endif
        end
      end
      default: begin
        // IDLE, DONE and ERROR all re-arm the same way.
        if (start) begin
          w_state_nxt    = S_WAIT;
          w_busy_nxt     = 1'b1;
          w_wait_idx_nxt = '0;
          w_done_nxt     = 1'b0;
          w_err_nxt      = 1'b0;
          w_err_code_nxt = 2'b00;
          w_err_idx_nxt  = '0;
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
          w_tmo_cnt_nxt  = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_wait_idx <= '0;
      r_hit      <= 1'b0;
      r_hit_idx  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_err_idx  <= '0;
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
      r_tmo_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= w_busy_nxt;
      r_wait_idx <= w_wait_idx_nxt;
      r_hit      <= w_hit_nxt;
      r_hit_idx  <= w_hit_idx_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
      r_err_idx  <= w_err_idx_nxt;
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
      r_tmo_cnt  <= w_tmo_cnt_nxt;
`endif
    end
  end

  assign busy     = r_busy;
  assign wait_idx = r_wait_idx;
  assign hit      = r_hit;
  assign hit_idx  = r_hit_idx;
  assign done     = r_done;
  assign err      = r_err;
  assign err_code = r_err_code;
  assign err_idx  = r_err_idx;

endmodule

// File: tb/tb_event_seq_waiter.sv
// tb/tb_event_seq_waiter.sv - self-checking bench for event_seq_waiter (N=4)

module tb_event_seq_waiter;

  localparam int N    = 4;
  localparam int IDXW = 2;
  localparam int TMO  = 5;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [N-1:0]    trig;
  logic            busy;
  logic [IDXW-1:0] wait_idx;
  logic            hit;
  logic [IDXW-1:0] hit_idx;
  logic            done;
  logic            err;
  logic [1:0]      err_code;
  logic [IDXW-1:0] err_idx;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  event_seq_waiter #(.N(N), .IDXW(IDXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trig(trig),
    .busy(busy), .wait_idx(wait_idx), .hit(hit), .hit_idx(hit_idx),
    .done(done), .err(err), .err_code(err_code), .err_idx(err_idx)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: "armed" means waiting; k is the next expected event number.
  bit m_armed, m_hit, m_done, m_err;
  int m_k, m_hit_idx, m_code, m_eidx, m_idle;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_armed = 0; m_hit = 0; m_done = 0; m_err = 0;
      m_k = 0; m_hit_idx = 0; m_code = 0; m_eidx = 0; m_idle = 0;
    end else begin
      int lowest_ahead;
      m_hit = 0;
      if (!m_armed) begin
        if (start) begin
          m_armed = 1; m_k = 0; m_done = 0; m_err = 0;
          m_code = 0; m_eidx = 0; m_idle = 0;
        end
      end else begin
        lowest_ahead = -1;
        for (int j = 0; j < N; j++)
          if (trig[j] && j > m_k && lowest_ahead < 0) lowest_ahead = j;
        if (lowest_ahead >= 0) begin
          m_armed = 0; m_err = 1; m_code = 1; m_eidx = lowest_ahead;
        end else if (trig[m_k]) begin
          m_hit = 1; m_hit_idx = m_k; m_idle = 0;
          if (m_k == N - 1) begin
            m_armed = 0; m_done = 1;
          end else begin
            m_k = m_k + 1;
          end
        end else begin
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
          m_idle = m_idle + 1;
          if (m_idle == TMO) begin
            m_armed = 0; m_err = 1; m_code = 2; m_eidx = m_k;
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_armed));
      chk("wait_idx", int'(wait_idx), m_k);
      chk("hit", int'(hit), int'(m_hit));
      if (m_hit) chk("hit_idx", int'(hit_idx), m_hit_idx);
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      chk("err_code", int'(err_code), m_code);
      chk("err_idx", int'(err_idx), m_eidx);
    end
  end

  task automatic step(input bit r, input bit s, input logic [N-1:0] t);
    rst_n = r; start = s; trig = t;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input bit s, input logic [N-1:0] t);
    step(1'b1, s, t);
  endtask

  initial begin
    rst_n = 0; start = 0; trig = '0;
    step(0, 0, 4'b0000);
    step(0, 1, 4'b1111);
    chk_en = 1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_wait_idx", int'(wait_idx), 0);
    chk("rst_err_code", int'(err_code), 0);

    // In-order back-to-back sequence.
    go(1, 4'b0000);
    chk("arm_busy", int'(busy), 1);
    go(0, 4'b0001);
    chk("seq_hit_idx0", int'(hit_idx), 0);
    go(0, 4'b0010);
    go(0, 4'b0100);
    chk("seq_wait_idx3", int'(wait_idx), 3);
    go(0, 4'b1000);
    chk("seq_done", int'(done), 1);
    chk("seq_hit_idx3", int'(hit_idx), 3);
    chk("seq_busy_low", int'(busy), 0);
    chk("seq_wait_hold", int'(wait_idx), 3);
    go(0, 4'b1111);
    chk("trig_ignored_done", int'(hit), 0);

    // Arm with trig[0] on the same edge: trig[0] must not be consumed.
    go(1, 4'b0001);
    chk("arm_trig0_nohit", int'(hit), 0);
    chk("arm_clears_done", int'(done), 0);
    go(0, 4'b0001);
    for (int i = 0; i < 3; i++) go(0, 4'b0000);
    go(0, 4'b0011);
    chk("stale_hit_idx1", int'(hit_idx), 1);
    chk("stale_err", int'(err), 0);
    go(0, 4'b0100);
    go(0, 4'b1000);
    chk("gap_done", int'(done), 1);

    // Early trigger with awaited bit also set: bits 1 and 3 while k=1.
    go(1, 4'b0000);
    go(0, 4'b0001);
    go(0, 4'b1010);
    chk("early_hit", int'(hit), 0);
    chk("early_err", int'(err), 1);
    chk("early_code", int'(err_code), 1);
    chk("early_idx", int'(err_idx), 3);
    go(0, 4'b0000);
    chk("early_sticky", int'(err), 1);

    // Early trigger at k=0, lowest early index chosen.
    go(1, 4'b0000);
    chk("rearm_err_clr", int'(err), 0);
    go(0, 4'b0110);
    chk("early_low_idx", int'(err_idx), 1);

    // Idle in WAIT.
    go(1, 4'b0000);
`ifdef EVENT_SEQ_WAITER_TIMEOUT_EN
    for (int i = 0; i < TMO - 1; i++) go(0, 4'b0000);
    chk("tmo_not_yet", int'(err), 0);
    go(0, 4'b0000);
    chk("tmo_err", int'(err), 1);
    chk("tmo_code", int'(err_code), 2);
    chk("tmo_idx", int'(err_idx), 0);
`else
    for (int i = 0; i < 100; i++) go(0, 4'b0000);
    chk("no_tmo_busy", int'(busy), 1);
`endif

    // Reset mid-sequence.
    go(1, 4'b0000);
    go(0, 4'b0001);
    go(0, 4'b0010);
    step(0, 0, 4'b0000);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wait_idx", int'(wait_idx), 0);
    chk("midrst_hit", int'(hit), 0);
    go(1, 4'b0000);
    chk("restart_wait_idx", int'(wait_idx), 0);
    chk("restart_busy", int'(busy), 1);

    // Start while busy is ignored; start after done re-arms.
    go(0, 4'b0001);
    go(0, 4'b0010);
    go(1, 4'b0000);
    chk("busy_start_wait_idx", int'(wait_idx), 2);
    go(0, 4'b0100);
    go(0, 4'b1000);
    chk("final_done", int'(done), 1);
    go(1, 4'b0000);
    chk("rearm_done_clr", int'(done), 0);
    chk("rearm_busy", int'(busy), 1);
    go(0, 4'b0000);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
